// File: rtl/sw_sort3_gen_pkg.sv
// Shared definitions for the three-value sorter: location indices, the
// one-hot location encoding and a one-hot test helper.
package sw_sort3_pkg;

  localparam int NLOC    = 7;
  localparam int SORT3_W = 3;

  localparam int LOC_IDLE = 0;
  localparam int LOC_XY   = 1;
  localparam int LOC_YZ   = 2;
  localparam int LOC_XY2  = 3;
  localparam int LOC_CHK  = 4;
  localparam int LOC_DONE = 5;
  localparam int LOC_ERR  = 6;

  typedef enum logic [NLOC-1:0] {
    L_IDLE = NLOC'(1 << LOC_IDLE),
    L_XY   = NLOC'(1 << LOC_XY),
    L_YZ   = NLOC'(1 << LOC_YZ),
    L_XY2  = NLOC'(1 << LOC_XY2),
    L_CHK  = NLOC'(1 << LOC_CHK),
    L_DONE = NLOC'(1 << LOC_DONE),
    L_ERR  = NLOC'(1 << LOC_ERR)
  } loc_e;

  // True when exactly one bit of the location vector is set
  function automatic logic isOneHot(input logic [NLOC-1:0] v);
    return (v != '0) && ((v & (v - NLOC'(1))) == '0);
  endfunction

endpackage

// File: rtl/sw_sort3_gen_if.sv
// Request/result bundle for the three-value sorter. The master drives the
// unordered operands and start; the slave (the sorter) returns the ordered
// triple and its status flags.
interface sw_sort3_gen_if #(parameter int W = 3);

  logic         start;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic [W-1:0] c_in;
  logic [W-1:0] x_out;
  logic [W-1:0] y_out;
  logic [W-1:0] z_out;
  logic         busy;
  logic         done;
  logic         err;

  modport master (
    output start, a_in, b_in, c_in,
    input  x_out, y_out, z_out, busy, done, err
  );

  modport slave (
    input  start, a_in, b_in, c_in,
    output x_out, y_out, z_out, busy, done, err
  );

endinterface

// File: rtl/sw_sort3_gen_cswap.sv
// Combinational compare-and-swap: with en set, the pair is reordered so that
// lo <= hi; equal operands are never exchanged, keeping ties stable. With en
// clear both operands pass straight through.
module sw_cswap
  import sw_sort3_pkg::*;
#(
  parameter int W = SORT3_W
) (
  input  logic [W-1:0] p,
  input  logic [W-1:0] q,
  input  logic         en,
  output logic [W-1:0] lo,
  output logic [W-1:0] hi
);

  logic doSwap;

  // Strict greater-than so that equal values keep their positions
  always_comb begin
    doSwap = en && (p > q);
    lo     = doSwap ? q : p;
    hi     = doSwap ? p : q;
  end

endmodule

// File: rtl/sw_sort3_gen.sv
// Three-value sorter driven by a one-hot program-location machine. Each
// location performs one compare-and-swap through a single shared cswap
// unit, then a check location confirms the ordering before signalling done.
// Reaching L_ERR would mean the network failed to order the triple; the
// no-error property states that this can never happen.
// Optional build macro: SW_SORT3_ONEHOT_GUARD_EN adds a registered one-hot
// health flag that freezes all state if the location vector is corrupted.
module sw_sort3_gen
  import sw_sort3_pkg::*;
#(
  parameter int W = SORT3_W
) (
  input  logic clk,
  input  logic rst,
  sw_sort3_gen_if.slave bus
);

  loc_e         loc_q;
  logic [W-1:0] x_q;
  logic [W-1:0] y_q;
  logic [W-1:0] z_q;

  logic [W-1:0] csP;
  logic [W-1:0] csQ;
  logic         csEn;
  logic [W-1:0] csLo;
  logic [W-1:0] csHi;
  logic         ordered;
  logic         stepEn;

  // Route the operand pair for the current location into the shared swapper
  always_comb begin
    csP  = x_q;
    csQ  = y_q;
    csEn = 1'b0;
    if (loc_q[LOC_XY] || loc_q[LOC_XY2]) begin
      csEn = 1'b1;
    end else if (loc_q[LOC_YZ]) begin
      csP  = y_q;
      csQ  = z_q;
      csEn = 1'b1;
    end
  end

  sw_cswap #(.W(W)) u_cswap (
    .p  (csP),
    .q  (csQ),
    .en (csEn),
    .lo (csLo),
    .hi (csHi)
  );

  assign ordered = (x_q <= y_q) && (y_q <= z_q);

`ifdef SW_SORT3_ONEHOT_GUARD_EN
  logic onehot_ok_q;

  // Track whether the location vector held exactly one set bit last cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      onehot_ok_q <= 1'b1;
    end else begin
      onehot_ok_q <= isOneHot(loc_q);
    end
  end

  assign stepEn = onehot_ok_q;
`else
  assign stepEn = 1'b1;
`endif

  // Program-location machine: load, three compare-and-swaps, check, done
  always_ff @(posedge clk) begin
    if (rst) begin
      loc_q <= L_IDLE;
      x_q   <= '0;
      y_q   <= '0;
      z_q   <= '0;
    end else if (stepEn) begin
      case (loc_q)
        L_IDLE: begin
          if (bus.start) begin
            x_q   <= bus.a_in;
            y_q   <= bus.b_in;
            z_q   <= bus.c_in;
            loc_q <= L_XY;
          end
        end
        L_XY: begin
          x_q   <= csLo;
          y_q   <= csHi;
          loc_q <= L_YZ;
        end
        L_YZ: begin
          y_q   <= csLo;
          z_q   <= csHi;
          loc_q <= L_XY2;
        end
        L_XY2: begin
          x_q   <= csLo;
          y_q   <= csHi;
          loc_q <= L_CHK;
        end
        L_CHK: begin
          loc_q <= ordered ? L_DONE : L_ERR;
        end
        L_DONE: begin
          loc_q <= L_IDLE;
        end
        L_ERR: begin
          loc_q <= L_ERR;
        end
        default: begin
          loc_q <= L_ERR;
        end
      endcase
    end
  end

  assign bus.x_out = x_q;
  assign bus.y_out = y_q;
  assign bus.z_out = z_q;
  assign bus.busy  = loc_q[LOC_XY] | loc_q[LOC_YZ] | loc_q[LOC_XY2] |
                     loc_q[LOC_CHK] | loc_q[LOC_DONE];
  assign bus.done  = loc_q[LOC_DONE];
  assign bus.err   = loc_q[LOC_ERR];

  // Safety property: the error location is never reached
  propNoErr: assert property (@(posedge clk) disable iff (rst) !bus.err);

`ifdef SW_SORT3_ONEHOT_GUARD_EN
  // The location vector always stays one-hot
  propOnehot: assert property (@(posedge clk) disable iff (rst) onehot_ok_q);
`endif

endmodule

// File: tb/tb_sw_sort3_gen.sv
// Bench for the three-value sorter. Stimulus pushes the expected ordered
// triple into a queue when a start is issued; an independent monitor pops
// and compares whenever done is presented.
module tb_sw_sort3_gen;

  localparam int W = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int testsRun    = 0;
  int testsFailed = 0;
  int doneCount   = 0;
  bit errSeen     = 1'b0;
  bit ohBad       = 1'b0;

  logic [3*W-1:0] expQ[$];

  always #5 clk = ~clk;

  sw_sort3_gen_if #(.W(W)) bus ();

  sw_sort3_gen #(.W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Record one comparison and report it if it does not match
  task automatic checkOutput(input string name, input int actual, input int required);
    testsRun++;
    if (actual != required) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, required);
    end
  endtask

  // Reference ordering built from min/max, independent of any swap network
  function automatic logic [3*W-1:0] sortModel(input int a, input int b, input int c);
    int lo, hi, mid;
    lo  = (a < b) ? a : b;
    lo  = (lo < c) ? lo : c;
    hi  = (a > b) ? a : b;
    hi  = (hi > c) ? hi : c;
    mid = a + b + c - lo - hi;
    return {W'(lo), W'(mid), W'(hi)};
  endfunction

  function automatic int pack3(input int x, input int y, input int z);
    return int'({W'(x), W'(y), W'(z)});
  endfunction

  // Wait for the sorter to be idle, then issue one start for a single cycle
  task automatic applyStimulus(input int a, input int b, input int c,
                               input bit doPush, input logic [3*W-1:0] expVal);
    int n;
    n = 0;
    @(negedge clk);
    while (bus.busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (bus.busy) checkOutput("idle wait timeout", 1, 0);
    bus.start = 1'b1;
    bus.a_in  = W'(a);
    bus.b_in  = W'(b);
    bus.c_in  = W'(c);
    if (doPush) expQ.push_back(expVal);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // Called in cycle t+1; checks done rises exactly at t+5 for one cycle
  task automatic waitLatency();
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 4) checkOutput("done early", int'(bus.done), 0);
      if (k == 5) checkOutput("done at t+5", int'(bus.done), 1);
    end
    @(negedge clk);
    checkOutput("done width", int'(bus.done), 0);
    checkOutput("busy after done", int'(bus.busy), 0);
  endtask

  // Scoreboard monitor
  initial begin
    logic [3*W-1:0] e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus.err) errSeen = 1'b1;
`ifdef SW_SORT3_ONEHOT_GUARD_EN
        if (!dut.onehot_ok_q) ohBad = 1'b1;
`endif
        if (bus.done) begin
          doneCount++;
          if (expQ.size() == 0) begin
            checkOutput("unexpected done", 1, 0);
          end else begin
            e = expQ.pop_front();
            checkOutput("sorted triple", int'({bus.x_out, bus.y_out, bus.z_out}), int'(e));
            checkOutput("err at done", int'(bus.err), 0);
          end
        end
      end
    end
  end

  // Watchdog
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    testsFailed++;
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed sequence
  initial begin
    int dc;
    bus.start = 1'b0;
    bus.a_in  = '0;
    bus.b_in  = '0;
    bus.c_in  = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checkOutput("reset xyz", int'({bus.x_out, bus.y_out, bus.z_out}), 0);
    checkOutput("reset busy", int'(bus.busy), 0);
    checkOutput("reset done", int'(bus.done), 0);
    checkOutput("reset err", int'(bus.err), 0);

    // 5,3,1 -> 1,3,5
    applyStimulus(5, 3, 1, 1'b1, 9'(pack3(1, 3, 5)));
    waitLatency();

    // 2,2,1 -> 1,2,2; after L_XY the tie is untouched
    applyStimulus(2, 2, 1, 1'b1, 9'(pack3(1, 2, 2)));
    @(negedge clk);
    @(negedge clk);
    checkOutput("tie after XY", int'({bus.x_out, bus.y_out, bus.z_out}), pack3(2, 2, 1));
    repeat (4) @(negedge clk);

    // Already sorted: values hold through every location
    applyStimulus(0, 4, 7, 1'b1, 9'(pack3(0, 4, 7)));
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      checkOutput("sorted hold", int'({bus.x_out, bus.y_out, bus.z_out}), pack3(0, 4, 7));
    end
    @(negedge clk);
    checkOutput("sorted done width", int'(bus.done), 0);
    checkOutput("sorted result kept", int'({bus.x_out, bus.y_out, bus.z_out}), pack3(0, 4, 7));

    // Continuous start: accepted once every six cycles
    @(negedge clk);
    dc = doneCount;
    bus.start = 1'b1;
    bus.a_in  = 3'd7;
    bus.b_in  = 3'd0;
    bus.c_in  = 3'd7;
    for (int i = 0; i < 24; i++) begin
      if (!bus.busy) expQ.push_back(9'(pack3(0, 7, 7)));
      @(negedge clk);
    end
    bus.start = 1'b0;
    repeat (8) @(negedge clk);
    checkOutput("held start sort count", doneCount - dc, 4);

    // Reset in L_YZ aborts the sort
    applyStimulus(6, 5, 4, 1'b0, '0);
    @(negedge clk);
    @(negedge clk);
    checkOutput("busy in YZ", int'(bus.busy), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("abort xyz", int'({bus.x_out, bus.y_out, bus.z_out}), 0);
    checkOutput("abort busy", int'(bus.busy), 0);
    checkOutput("abort done", int'(bus.done), 0);
    applyStimulus(1, 0, 2, 1'b1, 9'(pack3(0, 1, 2)));
    waitLatency();

    // Full sweep of every W=3 triple
    for (int a = 0; a < 8; a++) begin
      for (int b = 0; b < 8; b++) begin
        for (int c = 0; c < 8; c++) begin
          applyStimulus(a, b, c, 1'b1, sortModel(a, b, c));
          waitLatency();
        end
      end
    end

    repeat (4) @(negedge clk);
    checkOutput("queue drained", expQ.size(), 0);
    checkOutput("err never seen", int'(errSeen), 0);
    checkOutput("onehot always ok", int'(ohBad), 0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/sw_sort3_gen.md
Name: sw_sort3_gen

Overview:
- Producer-side companion to the team's ordered-triple checker benchmarks in the crafted software-model suite.
- Accepts three unordered W-bit values and drives them out as an ordered triple x <= y <= z.
- Control is a one-hot program-location machine (L_IDLE..L_ERR) with a compare-and-swap per location, in the same program-counter style as the checker benchmarks.
- Carries its own safety property: the error location is never reached.

Parameters:
- W, 3, data width of each value; all comparisons are unsigned, W-bit.

Ports:
- clk  input  1  single clock, all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request to sort; sampled only in L_IDLE.
- a_in  input  W  first value, captured with start.
- b_in  input  W  second value, captured with start.
- c_in  input  W  third value, captured with start.
- x_out  output  W  smallest value (register).
- y_out  output  W  middle value (register).
- z_out  output  W  largest value (register).
- busy  output  1  high when location is L_XY, L_YZ, L_XY2, L_CHK or L_DONE.
- done  output  1  high exactly while location is L_DONE (one-cycle pulse).
- err  output  1  high while location is L_ERR; sticky until rst.

Behaviour:
- Reset (rst=1 at posedge, wins over everything): location = L_IDLE only; x_out/y_out/z_out = 0; busy = 0; done = 0; err = 0. Reset mid-sort aborts with no partial result retained.
- Locations are one-hot registers: L_IDLE, L_XY, L_YZ, L_XY2, L_CHK, L_DONE, L_ERR.
- L_IDLE:
  - start=1: x,y,z <= a_in,b_in,c_in; go to L_XY.
  - start=0: hold.
- L_XY: if x > y, swap x and y; go to L_YZ.
- L_YZ: if y > z, swap y and z; go to L_XY2.
- L_XY2: if x > y, swap x and y; go to L_CHK.
- L_CHK: if x <= y and y <= z, go to L_DONE; otherwise go to L_ERR.
- L_DONE: go to L_IDLE.
- L_ERR: hold forever until rst.
- Equal values never swap (strict >), so ties are stable.
- Latency: start sampled in L_IDLE at cycle t → done=1 in cycle t+5. A new start is accepted at t+6 at the earliest.
- start outside L_IDLE is ignored and does not queue.
- x/y/z hold their values in every location that does not swap, and stay valid after L_DONE until the next accepted start.
- Data registers are only written at load or on a swap; no other update path exists.
- Property: prop = !err, asserted every cycle. It must be provable for all inputs and all W.

Optional Feature:
- Macro: SW_SORT3_ONEHOT_GUARD_EN.
- Defined:
  - Registered flag onehot_ok is updated every cycle to "exactly one location bit set", and resets to 1.
  - Every location transition and data write is gated by onehot_ok; when onehot_ok=0, all state holds.
  - A second property, prop_onehot = onehot_ok, is asserted.
- Undefined:
  - No guard flag; transitions are ungated.
  - Only prop is asserted.
- Cycle timing is identical in both builds.

Decomposition:
- Shared package sw_sort3_pkg holds:
  - location index constants (LOC_IDLE..LOC_ERR, 7 locations);
  - location vector width constant NLOC = 7;
  - default width constant SORT3_W = 3.
- One sub-module is natural: sw_cswap (combinational compare-and-swap).
  - Inputs: p, q (W bits) and en.
  - Outputs: lo, hi.
  - en=0 passes p,q through unchanged.
  - It is instantiated once, with operands muxed by location.

Test Plan:
- Reset then start with a,b,c = 5,3,1 → done at t+5; x,y,z = 1,3,5; err stays 0.
- Start with 2,2,1 → x,y,z = 1,2,2; equal values are not swapped in L_XY.
- Already sorted 0,4,7 → no swaps; outputs 0,4,7 in each of locations L_XY..L_DONE; done one cycle wide.
- Hold start=1 continuously with 7,0,7 → a sort is accepted every 6 cycles, outputs 0,7,7 each time; start ignored while busy.
- Assert rst in L_YZ during a 6,5,4 sort → next cycle in L_IDLE with outputs 0,0,0, busy=0; a following start with 1,0,2 gives 0,1,2.
- Exhaustive W=3 sweep (512 triples), run with and without SW_SORT3_ONEHOT_GUARD_EN → outputs are always sorted, err never 1, onehot_ok always 1.
